// File: rtl/led_blink_pkg.sv
`timescale 1ns/1ps
// Package: led_blink_pkg
// Purpose: types and helpers shared by the multi-channel LED pattern generator.
//   led_mode_t  per-channel pattern mode (OFF, ON, free-running BLINK, counted BURST)
//   ch_width()  width of a channel index; never narrower than one bit
package led_blink_pkg;

  typedef enum logic [1:0] {
    LM_OFF   = 2'd0,
    LM_ON    = 2'd1,
    LM_BLINK = 2'd2,
    LM_BURST = 2'd3
  } led_mode_t;

  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/led_blink_multi_if.sv
`timescale 1ns/1ps
// Interface: led_blink_multi_if
// Purpose: valid/ready configuration port of led_blink_multi.
//   cfg_valid  master->slave  write request
//   cfg_ready  slave->master  low while the block is held in reset
//   cfg_ch     master->slave  target channel (out-of-range values are ignored)
//   cfg_mode   master->slave  pattern mode
//   cfg_half   master->slave  half-period in prescaler ticks (0 acts as 1)
//   cfg_cnt    master->slave  BURST pulse count
interface led_blink_multi_if
  import led_blink_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PW  = 16,
  parameter int CW  = 8
) ();

  localparam int CHW = ch_width(NCH);

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_ch;
  led_mode_t       cfg_mode;
  logic [PW-1:0]   cfg_half;
  logic [CW-1:0]   cfg_cnt;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_half, cfg_cnt,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_half, cfg_cnt,
    output cfg_ready
  );

endinterface

// File: rtl/led_blink_chan.sv
`timescale 1ns/1ps
// Module: led_blink_chan
// Purpose: one LED channel. Holds mode, half-period, remaining burst count and
//   phase counter, and advances the pattern on each shared prescaler tick.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   tick          one-cycle prescaler strobe
//   load          config write for this channel; beats a simultaneous tick
//   mode/half/cnt config fields sampled when load is high
//   led           registered LED drive
//   busy          high while the channel runs BLINK or BURST
//   done          one-cycle pulse when a BURST completes (or is loaded with cnt=0)
module led_blink_chan
  import led_blink_pkg::*;
#(
  parameter int PW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  input  led_mode_t     mode,
  input  logic [PW-1:0] half,
  input  logic [CW-1:0] cnt,
  output logic          led,
  output logic          busy,
  output logic          done
);

  led_mode_t      mode_q;
  logic [PW-1:0]  half_q;
  logic [PW-1:0]  phase_q;
  logic [CW-1:0]  rem_q;
  logic           running;
  logic           phase_end;

  assign running   = (mode_q == LM_BLINK) || (mode_q == LM_BURST);
  assign busy      = running;
  assign phase_end = (phase_q == half_q - PW'(1));

  // NOTE: every register here is written with <= so all of them update from
  // the same pre-edge values; blocking writes would make later reads see new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= LM_OFF;
      half_q  <= PW'(1);
      phase_q <= '0;
      rem_q   <= '0;
      led     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        // A write aborts whatever was running, with no done for an aborted burst.
        mode_q  <= mode;
        half_q  <= (half == '0) ? PW'(1) : half;
        rem_q   <= cnt;
        phase_q <= '0;
        case (mode)
          LM_OFF:   led <= 1'b0;
          LM_ON:    led <= 1'b1;
          LM_BLINK: led <= 1'b1;
          LM_BURST: begin
            if (cnt == '0) begin
              // Empty burst finishes on the spot.
              led    <= 1'b0;
              mode_q <= LM_OFF;
              done   <= 1'b1;
            end else begin
              led <= 1'b1;
            end
          end
        endcase
      end else if (tick && running) begin
        if (phase_end) begin
          phase_q <= '0;
          led     <= ~led;
          // A pulse ends on its falling edge; that is where the count is spent.
          if ((mode_q == LM_BURST) && led) begin
            if (rem_q <= CW'(1)) begin
              rem_q  <= '0;
              mode_q <= LM_OFF;
              done   <= 1'b1;
            end else begin
              rem_q <= rem_q - CW'(1);
            end
          end
        end else begin
          phase_q <= phase_q + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/led_blink_multi.sv
`timescale 1ns/1ps
// Module: led_blink_multi
// Purpose: NCH-channel LED pattern generator. A shared prescaler divides clk
//   down to TICK_HZ; each channel runs OFF / ON / BLINK / BURST independently.
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high
//   cfg   configuration port (slave side of led_blink_multi_if)
//   led   per-channel LED drive, registered
//   busy  per-channel, high during BLINK or BURST
//   done  per-channel one-cycle pulse at BURST completion
module led_blink_multi
  import led_blink_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int NCH     = 4,
  parameter int PW      = 16,
  parameter int CW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  led_blink_multi_if.slave   cfg,
  output logic [NCH-1:0]     led,
  output logic [NCH-1:0]     busy,
  output logic [NCH-1:0]     done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PSW = $clog2(DIV) + 1;
  localparam int CHW = ch_width(NCH);

  logic [PSW-1:0] pre_cnt;
  logic           tick;
  logic           accept;

  // With DIV=1 the count is stuck at 0 and tick stays high every cycle.
  assign tick = (pre_cnt == PSW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PSW'(1);
  end

  assign cfg.cfg_ready = ~rst;
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

  // A channel index >= NCH matches no instance, so such writes are accepted
  // by the handshake and then have no effect.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic load;
    assign load = accept && (cfg.cfg_ch == CHW'(i));

    led_blink_chan #(
      .PW (PW),
      .CW (CW)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .load (load),
      .mode (cfg.cfg_mode),
      .half (cfg.cfg_half),
      .cnt  (cfg.cfg_cnt),
      .led  (led[i]),
      .busy (busy[i]),
      .done (done[i])
    );
  end

endmodule

// File: tb/tb_led_blink_multi.sv
`timescale 1ns/1ps
// Testbench: tb_led_blink_multi
// Directed tests of led_blink_multi at CLK_HZ=1000, TICK_HZ=100 (DIV=10).
// A second, 3-channel instance provides an unused channel index for the
// out-of-range write case. Inputs change just after falling edges; outputs
// are sampled on falling edges.
module tb_led_blink_multi;
  import led_blink_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] led, busy, done;
  logic [2:0] led3, busy3, done3;
  int         vec  = 0;
  int         miss = 0;
  int         pre;

  led_blink_multi_if #(.NCH(4), .PW(16), .CW(8)) cfg_if ();
  led_blink_multi_if #(.NCH(3), .PW(16), .CW(8)) cfg3_if ();

  led_blink_multi #(
    .CLK_HZ (1000), .TICK_HZ (100), .NCH (4), .PW (16), .CW (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cfg  (cfg_if.slave),
    .led  (led),
    .busy (busy),
    .done (done)
  );

  led_blink_multi #(
    .CLK_HZ (1000), .TICK_HZ (100), .NCH (3), .PW (16), .CW (8)
  ) dut3 (
    .clk  (clk),
    .rst  (rst),
    .cfg  (cfg3_if.slave),
    .led  (led3),
    .busy (busy3),
    .done (done3)
  );

  always #5 clk = ~clk;

  // Expected prescaler position; the next rising edge is a tick edge when pre==9.
  always @(posedge clk or posedge rst) begin
    if (rst) pre <= 0;
    else     pre <= (pre == 9) ? 0 : pre + 1;
  end

  // Called on a falling edge; returns on the falling edge after the accept edge.
  task automatic cfg_write(input int ch, input led_mode_t m, input int half,
                           input int cnt, input bit at_tick);
    if (at_tick) while (pre != 9) @(negedge clk);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_mode  = m;
    cfg_if.cfg_half  = 16'(half);
    cfg_if.cfg_cnt   = 8'(cnt);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vec++;
    if ({cfg_if.cfg_ready, led, busy, done} !== 13'd0) begin
      miss++;
      $display("FAIL in_reset: ready/led/busy/done=%0h expected 0", {cfg_if.cfg_ready, led, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec++;
    if ({cfg_if.cfg_ready, led, busy, done} !== {1'b1, 12'd0}) begin
      miss++;
      $display("FAIL reset_release: ready/led/busy/done=%0h expected 1000", {cfg_if.cfg_ready, led, busy, done});
    end
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      vec++;
      if (dut.tick !== (pre == 9)) begin
        miss++;
        $display("FAIL tick_period: cycle %0d tick=%0b expected %0b", c, dut.tick, (pre == 9));
      end
    end
  endtask

  task automatic test_blink();
    logic exp_led;
    cfg_write(0, LM_BLINK, 3, 0, 1'b1);
    vec++;
    if ({led[0], busy[0]} !== 2'b11) begin
      miss++;
      $display("FAIL blink_load: led0/busy0=%0b%0b expected 11", led[0], busy[0]);
    end
    for (int e = 1; e <= 90; e++) begin
      @(negedge clk);
      exp_led = ((e / 30) % 2) == 0;
      vec++;
      if ({led[0], busy[0]} !== {exp_led, 1'b1}) begin
        miss++;
        $display("FAIL blink_run: cycle %0d led0/busy0=%0b%0b expected %0b1", e, led[0], busy[0], exp_led);
      end
    end
  endtask

  task automatic test_burst();
    logic exp_led, exp_busy, exp_done;
    int   pulses = 0;
    cfg_write(1, LM_BURST, 1, 2, 1'b1);
    vec++;
    if ({led[1], busy[1], done[1]} !== 3'b110) begin
      miss++;
      $display("FAIL burst_load: led1/busy1/done1=%0b%0b%0b expected 110", led[1], busy[1], done[1]);
    end
    for (int e = 1; e <= 45; e++) begin
      @(negedge clk);
      exp_led  = (e < 10) || (e >= 20 && e < 30);
      exp_busy = (e < 30);
      exp_done = (e == 30);
      if (done[1] === 1'b1) pulses++;
      vec++;
      if ({led[1], busy[1], done[1]} !== {exp_led, exp_busy, exp_done}) begin
        miss++;
        $display("FAIL burst_run: cycle %0d led1/busy1/done1=%0b%0b%0b expected %0b%0b%0b",
                 e, led[1], busy[1], done[1], exp_led, exp_busy, exp_done);
      end
    end
    vec++;
    if (pulses != 1) begin
      miss++;
      $display("FAIL burst_done_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_burst_zero();
    cfg_write(2, LM_BURST, 5, 0, 1'b0);
    vec++;
    if ({led[2], busy[2], done[2]} !== 3'b001) begin
      miss++;
      $display("FAIL burst0_accept: led2/busy2/done2=%0b%0b%0b expected 001", led[2], busy[2], done[2]);
    end
    @(negedge clk);
    vec++;
    if ({led[2], busy[2], done[2]} !== 3'b000) begin
      miss++;
      $display("FAIL burst0_after: led2/busy2/done2=%0b%0b%0b expected 000", led[2], busy[2], done[2]);
    end
  endtask

  task automatic test_abort();
    cfg_write(1, LM_BURST, 2, 3, 1'b1);
    repeat (15) @(negedge clk);
    vec++;
    if ({led[1], busy[1]} !== 2'b11) begin
      miss++;
      $display("FAIL abort_pre: led1/busy1=%0b%0b expected 11", led[1], busy[1]);
    end
    cfg_write(1, LM_OFF, 1, 0, 1'b0);
    for (int e = 0; e <= 60; e++) begin
      vec++;
      if ({led[1], busy[1], done[1]} !== 3'b000) begin
        miss++;
        $display("FAIL abort_off: cycle %0d led1/busy1/done1=%0b%0b%0b expected 000", e, led[1], busy[1], done[1]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_tick_write();
    logic exp_led;
    cfg_write(3, LM_BLINK, 2, 0, 1'b1);
    // Rewrite lands on the very next tick edge: phase restarts, no advance.
    cfg_write(3, LM_BLINK, 2, 0, 1'b1);
    vec++;
    if ({led[3], busy[3]} !== 2'b11) begin
      miss++;
      $display("FAIL tickwrite_load: led3/busy3=%0b%0b expected 11", led[3], busy[3]);
    end
    for (int r = 1; r <= 25; r++) begin
      @(negedge clk);
      exp_led = (r < 20);
      vec++;
      if (led[3] !== exp_led) begin
        miss++;
        $display("FAIL tickwrite_run: cycle %0d led3=%0b expected %0b", r, led[3], exp_led);
      end
    end
  endtask

  task automatic test_bad_channel();
    cfg3_if.cfg_valid = 1'b1;
    cfg3_if.cfg_ch    = 2'd0;
    cfg3_if.cfg_mode  = LM_ON;
    @(negedge clk);
    cfg3_if.cfg_ch    = 2'd3;
    cfg3_if.cfg_mode  = LM_BLINK;
    cfg3_if.cfg_half  = 16'd1;
    vec++;
    if ({led3, busy3} !== 6'b001_000) begin
      miss++;
      $display("FAIL badch_setup: led3/busy3=%0b/%0b expected 001/000", led3, busy3);
    end
    @(negedge clk);
    cfg3_if.cfg_valid = 1'b0;
    for (int e = 0; e < 25; e++) begin
      vec++;
      if ({led3, busy3, done3} !== 9'b001_000_000) begin
        miss++;
        $display("FAIL badch_ignored: cycle %0d led/busy/done=%0b/%0b/%0b expected 001/000/000", e, led3, busy3, done3);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    vec++;
    if (busy !== 4'b1001) begin
      miss++;
      $display("FAIL pre_reset_busy: got %0b expected 1001", busy);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({cfg_if.cfg_ready, led, busy, done, led3} !== 16'd0) begin
      miss++;
      $display("FAIL async_reset: ready/led/busy/done/led3=%0h expected 0", {cfg_if.cfg_ready, led, busy, done, led3});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec++;
    if ({cfg_if.cfg_ready, led, busy, done} !== {1'b1, 12'd0}) begin
      miss++;
      $display("FAIL post_reset: ready/led/busy/done=%0h expected 1000", {cfg_if.cfg_ready, led, busy, done});
    end
    for (int e = 0; e < 50; e++) begin
      @(negedge clk);
      vec++;
      if ({led, busy, done, led3} !== 15'd0) begin
        miss++;
        $display("FAIL no_resume: cycle %0d led/busy/done/led3=%0h expected 0", e, {led, busy, done, led3});
      end
    end
  endtask

  initial begin
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_mode   = LM_OFF;
    cfg_if.cfg_half   = '0;
    cfg_if.cfg_cnt    = '0;
    cfg3_if.cfg_valid = 1'b0;
    cfg3_if.cfg_ch    = '0;
    cfg3_if.cfg_mode  = LM_OFF;
    cfg3_if.cfg_half  = '0;
    cfg3_if.cfg_cnt   = '0;

    test_reset();
    test_blink();
    test_burst();
    test_burst_zero();
    test_abort();
    test_tick_write();
    test_bad_channel();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
